// File: rtl/tas_avg.sv
// Serial temperature packet averager: deserialises header+sample bytes, averages
// 2^LOG2_AVG samples from valid packets and writes each average to sequential RAM addresses.
module tas_avg #(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       ADDR_W    = 11,
    parameter int unsigned       LOG2_AVG  = 2,
    parameter logic [DATA_W-1:0] HDR_VALID = DATA_W'(8'hA5),
    parameter bit                ADDR_DIR  = 1'b0
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              serial_data,
    input  logic              data_ena,
    output logic              ram_wr_n,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              pkt_drop
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned ACC_W = DATA_W + LOG2_AVG;
    localparam int unsigned CNT_W = LOG2_AVG + 1;

    localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  NUM_SAMPLES = CNT_W'(1) << LOG2_AVG;
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'((1 << LOG2_AVG) - 1);
    localparam logic [ADDR_W-1:0] ADDR_START  = ADDR_DIR ? {ADDR_W{1'b0}} : {ADDR_W{1'b1}};

    typedef enum logic [1:0] {StHdr, StSample, StSkip, StWrite} state_e;

    logic [BIT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic              byte_done_q;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              wr_n_q, wr_n_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              drop_q, drop_d;

    // shift_q holds the completed byte during the byte_done_q cycle, even if
    // the next byte has already started shifting in.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte_done_q <= 1'b0;
        end else begin
            byte_done_q <= 1'b0;
            if (data_ena) begin
                shift_q <= {shift_q[DATA_W-2:0], serial_data};
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_q   <= '0;
                    byte_done_q <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end else begin
                bit_cnt_q <= '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        wr_n_d  = 1'b1;
        data_d  = data_q;
        addr_d  = addr_q;
        drop_d  = 1'b0;

        if (state_q == StWrite) begin
            addr_d = ADDR_DIR ? addr_q + 1'b1 : addr_q - 1'b1;
        end

        unique case (state_q)
            // A byte landing in the write cycle is treated as a header, so nothing is lost.
            StHdr, StWrite: begin
                if (state_q == StWrite) state_d = StHdr;
                if (byte_done_q) begin
                    cnt_d = '0;
                    if (shift_q == HDR_VALID) begin
                        acc_d   = '0;
                        state_d = StSample;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = StSkip;
                    end
                end
            end
            StSample: begin
                if (cnt_q == NUM_SAMPLES) begin
                    state_d = StWrite;
                    wr_n_d  = 1'b0;
                    data_d  = acc_q[ACC_W-1:LOG2_AVG];
                end else if (byte_done_q) begin
                    acc_d = acc_q + ACC_W'(shift_q);
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSkip: begin
                if (byte_done_q) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = StHdr;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StHdr;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q <= StHdr;
            cnt_q   <= '0;
            acc_q   <= '0;
            wr_n_q  <= 1'b1;
            data_q  <= '0;
            addr_q  <= ADDR_START;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            wr_n_q  <= wr_n_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            drop_q  <= drop_d;
        end
    end

    assign ram_wr_n = wr_n_q;
    assign ram_data = data_q;
    assign ram_addr = addr_q;
    assign pkt_drop = drop_q;

endmodule

// File: tb/tb_tas_avg.sv
// Directed bench for tas_avg: three instances cover the default build, a 2-bit
// address wrap, and an incrementing single-sample build.
module tb_tas_avg;

    logic clk = 1'b0;
    logic reset;
    logic ser [3];
    logic ena [3];

    logic        wr_n0, wr_n1, wr_n2;
    logic [7:0]  data0, data1, data2;
    logic [10:0] addr0, addr2;
    logic [1:0]  addr1;
    logic        drop0, drop1, drop2;

    always #5 clk = ~clk;

    tas_avg u_def (
        .clk_50(clk), .reset(reset), .serial_data(ser[0]), .data_ena(ena[0]),
        .ram_wr_n(wr_n0), .ram_data(data0), .ram_addr(addr0), .pkt_drop(drop0)
    );

    tas_avg #(.ADDR_W(2)) u_wrap (
        .clk_50(clk), .reset(reset), .serial_data(ser[1]), .data_ena(ena[1]),
        .ram_wr_n(wr_n1), .ram_data(data1), .ram_addr(addr1), .pkt_drop(drop1)
    );

    tas_avg #(.ADDR_DIR(1'b1), .LOG2_AVG(0)) u_inc (
        .clk_50(clk), .reset(reset), .serial_data(ser[2]), .data_ena(ena[2]),
        .ram_wr_n(wr_n2), .ram_data(data2), .ram_addr(addr2), .pkt_drop(drop2)
    );

    // Write/drop capture, sampled on the falling edge.
    logic [7:0]  wdata [3][32];
    logic [10:0] waddr [3][32];
    int wcnt [3];
    int dcnt [3];
    int wrun [3];
    int wmax [3];
    int drun [3];
    int dmax [3];

    task automatic mon(input int i, input logic wn, input logic [7:0] d,
                       input logic [10:0] a, input logic dr);
        if (!wn) begin
            if (wcnt[i] < 32) begin
                wdata[i][wcnt[i]] = d;
                waddr[i][wcnt[i]] = a;
            end
            wcnt[i]++;
            wrun[i]++;
            if (wrun[i] > wmax[i]) wmax[i] = wrun[i];
        end else begin
            wrun[i] = 0;
        end
        if (dr) begin
            dcnt[i]++;
            drun[i]++;
            if (drun[i] > dmax[i]) dmax[i] = drun[i];
        end else begin
            drun[i] = 0;
        end
    endtask

    always @(negedge clk) begin
        mon(0, wr_n0, data0, addr0, drop0);
        mon(1, wr_n1, data1, {9'd0, addr1}, drop1);
        mon(2, wr_n2, data2, addr2, drop2);
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input int inst, input logic [7:0] b, input bit keep);
        for (int i = 7; i >= 0; i--) begin
            ser[inst] = b[i];
            ena[inst] = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!keep) ena[inst] = 1'b0;
    endtask

    task automatic send_pkt(input int inst, input logic [4:0][7:0] p);
        for (int k = 4; k >= 0; k--) begin
            send_byte(inst, p[k], 1'b0);
            idle(2);
        end
        idle(8);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    typedef struct packed {
        logic            rst;
        logic [4:0][7:0] b;
        logic            exp_wr;
        logic [7:0]      exp_data;
        logic [10:0]     exp_addr;
        logic            exp_drop;
    } vec_t;

    vec_t vecs [9];
    logic [1:0] exp_wrap [5];
    logic [7:0] exp_inc  [3];

    initial begin
        int w0;
        int d0;

        vecs[0] = '{1'b1, {8'hA5, 8'd10, 8'd20, 8'd30, 8'd40},     1'b1, 8'd25,  11'h7FF, 1'b0};
        vecs[1] = '{1'b0, {8'hA5, 8'd10, 8'd20, 8'd30, 8'd40},     1'b1, 8'd25,  11'h7FE, 1'b0};
        vecs[2] = '{1'b1, {8'hC3, 8'd1, 8'd2, 8'd3, 8'd4},         1'b0, 8'd0,   11'h000, 1'b1};
        vecs[3] = '{1'b0, {8'hA5, 8'd1, 8'd2, 8'd2, 8'd2},         1'b1, 8'd1,   11'h7FF, 1'b0};
        vecs[4] = '{1'b0, {8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF},     1'b1, 8'hFF,  11'h7FE, 1'b0};
        vecs[5] = '{1'b0, {8'hA5, 8'd0, 8'd1, 8'd2, 8'd3},         1'b1, 8'd1,   11'h7FD, 1'b0};
        vecs[6] = '{1'b0, {8'h5A, 8'hA5, 8'hA5, 8'hA5, 8'hA5},     1'b0, 8'd0,   11'h000, 1'b1};
        vecs[7] = '{1'b0, {8'hA5, 8'd100, 8'd100, 8'd100, 8'd103}, 1'b1, 8'd100, 11'h7FC, 1'b0};
        vecs[8] = '{1'b0, {8'hA5, 8'd3, 8'd3, 8'd3, 8'd2},         1'b1, 8'd2,   11'h7FB, 1'b0};

        exp_wrap[0] = 2'd3; exp_wrap[1] = 2'd2; exp_wrap[2] = 2'd1;
        exp_wrap[3] = 2'd0; exp_wrap[4] = 2'd3;
        exp_inc[0] = 8'h07; exp_inc[1] = 8'h3C; exp_inc[2] = 8'hE1;

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ser[i] = 1'b0;
            ena[i] = 1'b0;
        end
        idle(3);

        // Outputs while held in reset
        check("rst_wr_n0", 32'(wr_n0), 32'd1);
        check("rst_data0", 32'(data0), 32'd0);
        check("rst_addr0", 32'(addr0), 32'h7FF);
        check("rst_drop0", 32'(drop0), 32'd0);
        check("rst_addr1", 32'(addr1), 32'd3);
        check("rst_addr2", 32'(addr2), 32'd0);
        check("rst_wr_n2", 32'(wr_n2), 32'd1);

        // A header shifted in during reset must be ignored
        send_byte(0, 8'hA5, 1'b0);
        check("rst_hold_addr0", 32'(addr0), 32'h7FF);
        reset = 1'b0;
        w0 = wcnt[0];
        d0 = dcnt[0];
        for (int k = 0; k < 4; k++) begin
            send_byte(0, 8'd10 + 8'(k * 10), 1'b0);
            idle(2);
        end
        idle(8);
        check("rst_ignore_wr", 32'(wcnt[0] - w0), 32'd0);
        check("rst_ignore_drop", 32'(dcnt[0] - d0), 32'd1);

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].rst) do_reset();
            w0 = wcnt[0];
            d0 = dcnt[0];
            send_pkt(0, vecs[v].b);
            check($sformatf("v%0d_nwr", v), 32'(wcnt[0] - w0), 32'(vecs[v].exp_wr));
            check($sformatf("v%0d_ndrop", v), 32'(dcnt[0] - d0), 32'(vecs[v].exp_drop));
            if (vecs[v].exp_wr) begin
                check($sformatf("v%0d_data", v), 32'(wdata[0][w0]), 32'(vecs[v].exp_data));
                check($sformatf("v%0d_addr", v), 32'(waddr[0][w0]), 32'(vecs[v].exp_addr));
            end
        end

        // Write latency: strobe cycle, one more cycle, then the write cycle
        do_reset();
        send_byte(0, 8'hA5, 1'b0); idle(2);
        send_byte(0, 8'd10, 1'b0); idle(2);
        send_byte(0, 8'd20, 1'b0); idle(2);
        send_byte(0, 8'd30, 1'b0); idle(2);
        send_byte(0, 8'd40, 1'b0);
        idle(1);
        check("lat_early_wr_n", 32'(wr_n0), 32'd1);
        idle(1);
        check("lat_wr_n", 32'(wr_n0), 32'd0);
        check("lat_data", 32'(data0), 32'd25);
        check("lat_addr", 32'(addr0), 32'h7FF);
        idle(1);
        check("post_wr_n", 32'(wr_n0), 32'd1);
        check("post_addr", 32'(addr0), 32'h7FE);
        check("post_data_hold", 32'(data0), 32'd25);
        reset = 1'b1;
        idle(1);
        check("rst_again_addr", 32'(addr0), 32'h7FF);
        check("rst_again_data", 32'(data0), 32'd0);
        reset = 1'b0;

        // Partial byte abandoned mid-packet
        do_reset();
        w0 = wcnt[0];
        send_byte(0, 8'hA5, 1'b0);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            ser[0] = 1'b1;
            ena[0] = 1'b1;
            idle(1);
        end
        ena[0] = 1'b0;
        idle(2);
        for (int k = 0; k < 4; k++) begin
            send_byte(0, 8'd8, 1'b0);
            idle(2);
        end
        idle(8);
        check("part_nwr", 32'(wcnt[0] - w0), 32'd1);
        check("part_data", 32'(wdata[0][w0]), 32'd8);
        check("part_addr", 32'(waddr[0][w0]), 32'h7FF);

        // Reset after the third sample abandons the packet
        do_reset();
        w0 = wcnt[0];
        send_byte(0, 8'hA5, 1'b0); idle(2);
        send_byte(0, 8'd1, 1'b0);  idle(2);
        send_byte(0, 8'd2, 1'b0);  idle(2);
        send_byte(0, 8'd3, 1'b0);  idle(2);
        do_reset();
        send_pkt(0, {8'hA5, 8'd4, 8'd4, 8'd4, 8'd4});
        check("abort_nwr", 32'(wcnt[0] - w0), 32'd1);
        check("abort_data", 32'(wdata[0][w0]), 32'd4);
        check("abort_addr", 32'(waddr[0][w0]), 32'h7FF);

        // 2-bit address wrap
        do_reset();
        w0 = wcnt[1];
        for (int p = 0; p < 5; p++) send_pkt(1, {8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF});
        check("wrap_nwr", 32'(wcnt[1] - w0), 32'd5);
        for (int p = 0; p < 5; p++) begin
            check($sformatf("wrap%0d_addr", p), 32'(waddr[1][w0 + p]), 32'(exp_wrap[p]));
            check($sformatf("wrap%0d_data", p), 32'(wdata[1][w0 + p]), 32'hFF);
        end

        // Incrementing, single-sample packets streamed back to back
        w0 = wcnt[2];
        for (int p = 0; p < 3; p++) begin
            send_byte(2, 8'hA5, 1'b1);
            send_byte(2, exp_inc[p], p != 2);
        end
        idle(10);
        check("inc_nwr", 32'(wcnt[2] - w0), 32'd3);
        for (int p = 0; p < 3; p++) begin
            check($sformatf("inc%0d_addr", p), 32'(waddr[2][w0 + p]), 32'(p));
            check($sformatf("inc%0d_data", p), 32'(wdata[2][w0 + p]), 32'(exp_inc[p]));
        end

        check("wr_pulse_max0", 32'(wmax[0]), 32'd1);
        check("wr_pulse_max1", 32'(wmax[1]), 32'd1);
        check("wr_pulse_max2", 32'(wmax[2]), 32'd1);
        check("drop_pulse_max0", 32'(dmax[0]), 32'd1);
        check("drop_none1", 32'(dcnt[1]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tas_avg.md
TAS_AVG -- requirements
Module: tas_avg

Interface
REQ-001 Parameter DATA_W, default 8, sets the serial byte and temperature sample width in bits.
REQ-002 Parameter ADDR_W, default 11, sets the RAM address width.
REQ-003 Parameter LOG2_AVG, default 2, sets the samples per packet and average to 2^LOG2_AVG (legal range 0..4).
REQ-004 Parameter HDR_VALID, default 8'hA5 (DATA_W bits), is the header value that marks a packet to average.
REQ-005 Parameter ADDR_DIR, default 0, selects the address direction: 0 = start at 2^ADDR_W-1 and decrement, 1 = start at 0 and increment.
REQ-006 Port clk_50, input, 1 bit, is the single clock; all logic is clocked on its rising edge.
REQ-007 Port reset, input, 1 bit, is a synchronous, active-high reset.
REQ-008 Port serial_data, input, 1 bit, is serial data sampled on clk_50 while data_ena=1, MSB first.
REQ-009 Port data_ena, input, 1 bit, is the serial enable; a byte is DATA_W consecutive cycles with data_ena=1.
REQ-010 Port ram_wr_n, output, 1 bit, is the active-low RAM write strobe.
REQ-011 Port ram_data, output, DATA_W bits, is the averaged temperature written to RAM.
REQ-012 Port ram_addr, output, ADDR_W bits, is the RAM write address.
REQ-013 Port pkt_drop, output, 1 bit, is a one-cycle pulse when a packet header is rejected.

Function
REQ-014 The deserialiser shall shift serial_data in on each data_ena=1 cycle and mark a byte complete on the DATA_W-th consecutive enabled cycle.
REQ-015 If data_ena falls before DATA_W bits are collected, the partial byte shall be discarded, the bit count cleared, and the FSM state left unchanged.
REQ-016 A byte-complete strobe shall go high in the cycle after the last bit is sampled; the next byte may begin in that same cycle.
REQ-017 The FSM shall have states HDR, SAMPLE, SKIP and WRITE, and shall reset to HDR.
REQ-018 In HDR, a byte equal to HDR_VALID shall clear the accumulator and the sample count and move the FSM to SAMPLE.
REQ-019 In HDR, any other byte shall pulse pkt_drop for one cycle and move the FSM to SKIP.
REQ-020 In SKIP, the FSM shall discard 2^LOG2_AVG bytes, then return to HDR; no write shall occur.
REQ-021 In SAMPLE, each byte shall be added into an accumulator of width DATA_W+LOG2_AVG, which cannot overflow.
REQ-022 After the 2^LOG2_AVG-th sample in SAMPLE, the FSM shall move to WRITE.
REQ-023 The average shall be the accumulator shifted right by LOG2_AVG, truncated with no rounding; it is always at most 2^DATA_W-1.
REQ-024 WRITE shall last exactly one cycle: ram_wr_n=0, ram_data=average, ram_addr=current address, all driven from registers.
REQ-025 ram_wr_n shall go low in the second cycle after the byte-complete strobe of the last sample.
REQ-026 In the cycle after WRITE: ram_wr_n=1, the FSM returns to HDR, and the address advances by 1 in the ADDR_DIR direction.
REQ-027 ram_data and ram_addr shall hold their values while ram_wr_n=1.
REQ-028 The address shall wrap modulo 2^ADDR_W: 0 to 2^ADDR_W-1 when decrementing, and 2^ADDR_W-1 to 0 when incrementing.
REQ-029 A byte completing during WRITE shall be accepted and processed in HDR state with no loss.
REQ-030 ram_wr_n=0 shall never be asserted for more than one consecutive cycle.

Reset
REQ-031 While reset=1: ram_wr_n=1, ram_data=0, pkt_drop=0, and ram_addr = 2^ADDR_W-1 (ADDR_DIR=0) or 0 (ADDR_DIR=1).
REQ-032 While reset=1, the FSM shall be in HDR and the bit count, sample count and accumulator shall be 0.
REQ-033 Reset asserted mid-byte, mid-packet or during WRITE shall abandon the operation; a pending write shall not occur and the address shall return to its start value.
REQ-034 Input bits presented while reset=1 shall be ignored.

Verification (defaults unless stated)
REQ-035 Header A5 then samples 10,20,30,40 -> single ram_wr_n=0 cycle with ram_data=25 and ram_addr=0x7FF; a second identical packet -> ram_data=25 at ram_addr=0x7FE.
REQ-036 Header C3 then 4 bytes, then A5 with samples 1,2,2,2 -> one pkt_drop pulse, no write for the C3 packet, then a write with ram_data=1 (7>>2, truncated) at 0x7FF.
REQ-037 Samples FF,FF,FF,FF -> ram_data=FF; with ADDR_W=2, five packets -> addresses 3,2,1,0,3 (wrap).
REQ-038 data_ena dropped after 5 bits of a sample, then 4 full samples 8,8,8,8 -> partial byte ignored, ram_data=8.
REQ-039 Reset pulsed after the 3rd sample of a packet -> no write; the next full packet writes to 0x7FF.
REQ-040 ADDR_DIR=1, LOG2_AVG=0, back-to-back packets with no idle cycles -> each sample written unchanged at addresses 0,1,2.
